// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-2 shift/rotate pipeline: operation codes,
// per-word-width sigma rotate/shift constants and rotr/shr helpers.
// The helpers operate on a 64-bit container; the low w bits carry the word.
package sha_pkg;

    typedef enum logic [2:0] {
        OP_ROTR  = 3'd0,
        OP_ROTL  = 3'd1,
        OP_SHR   = 3'd2,
        OP_SHL   = 3'd3,
        OP_BSIG0 = 3'd4,
        OP_BSIG1 = 3'd5,
        OP_SSIG0 = 3'd6,
        OP_SSIG1 = 3'd7
    } op_e;

    // Rows: BSIG0, BSIG1, SSIG0, SSIG1. Columns: three term amounts.
    // The third term of SSIG0/SSIG1 is a logical shift, all others rotate.
    localparam int unsigned SIG32 [4][3] = '{
        '{ 2, 13, 22}, '{ 6, 11, 25}, '{ 7, 18,  3}, '{17, 19, 10}
    };
    localparam int unsigned SIG64 [4][3] = '{
        '{28, 34, 39}, '{14, 18, 41}, '{ 1,  8,  7}, '{19, 61,  6}
    };

    function automatic int unsigned sig_k(input int unsigned w,
                                          input int unsigned f,
                                          input int unsigned k);
        return (w == 64) ? SIG64[f][k] : SIG32[f][k];
    endfunction

    function automatic logic [63:0] word_mask(input int unsigned w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x,
                                         input int unsigned n,
                                         input int unsigned w);
        logic [63:0] m;
        logic [63:0] xm;
        m  = word_mask(w);
        xm = x & m;
        if (n % w == 0) return xm;
        return ((xm >> n) | (xm << (w - n))) & m;
    endfunction

    function automatic logic [63:0] shr(input logic [63:0] x,
                                        input int unsigned n,
                                        input int unsigned w);
        return (x & word_mask(w)) >> n;
    endfunction

endpackage

// File: rtl/sha_barrel.sv
// Combinational barrel shifter with runtime amount.
// Ports: data_i   operand
//        amt_i    shift amount (mod WIDTH by construction)
//        left_i   1 = shift/rotate left, 0 = right
//        rotate_i 1 = rotate, 0 = logical shift with zero fill
//        data_o   result
module sha_barrel #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             left_i,
    input  logic             rotate_i,
    output logic [WIDTH-1:0] data_o
);

    logic [2*WIDTH-1:0] dbl;

    // Rotation shifts a doubled copy of the word; the wrapped bits fall into
    // the half that is kept.
    always_comb begin
        dbl    = '0;
        data_o = '0;
        unique case ({rotate_i, left_i})
            2'b10: begin
                dbl    = {data_i, data_i} >> amt_i;
                data_o = dbl[WIDTH-1:0];
            end
            2'b11: begin
                dbl    = {data_i, data_i} << amt_i;
                data_o = dbl[2*WIDTH-1:WIDTH];
            end
            2'b00:   data_o = data_i >> amt_i;
            default: data_o = data_i << amt_i;
        endcase
    end

endmodule

// File: rtl/sha_shift_pipe.sv
// Two-stage pipelined shift/rotate/sigma engine for the SHA-2 datapath.
// Ports: clk, rst (async, active high)
//        in_valid/in_ready/in_data/in_amt/in_op/in_tag   input handshake
//        out_valid/out_ready/out_data/out_tag            output handshake
// S1 registers three candidate terms and the tag, S2 registers their XOR.
module sha_shift_pipe
    import sha_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("sha_shift_pipe: WIDTH must be 32 or 64");
    end

    op_e              op;
    logic [WIDTH-1:0] barrel_out;
    logic [63:0]      x64;
    int unsigned      f;
    logic [WIDTH-1:0] t0_d, t1_d, t2_d;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_t0_q, s1_t1_q, s1_t2_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic [TAG_W-1:0] s2_tag_q;
    logic             s2_adv;

    assign op  = op_e'(in_op);
    assign x64 = 64'(in_data);
    assign f   = 32'(in_op[1:0]);

    sha_barrel #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_barrel (
        .data_i   (in_data),
        .amt_i    (in_amt),
        .left_i   (op == OP_ROTL || op == OP_SHL),
        .rotate_i (op == OP_ROTR || op == OP_ROTL),
        .data_o   (barrel_out)
    );

    // Sigma amounts are constants per row, so the rotations reduce to wiring.
    always_comb begin
        t0_d = '0;
        t1_d = '0;
        t2_d = '0;
        if (!in_op[2]) begin
            t0_d = barrel_out;
        end else begin
            t0_d = WIDTH'(rotr(x64, sig_k(WIDTH, f, 0), WIDTH));
            t1_d = WIDTH'(rotr(x64, sig_k(WIDTH, f, 1), WIDTH));
            t2_d = in_op[1] ? WIDTH'(shr(x64, sig_k(WIDTH, f, 2), WIDTH))
                            : WIDTH'(rotr(x64, sig_k(WIDTH, f, 2), WIDTH));
        end
    end

    assign s2_adv    = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_adv;
    assign s2_data_d = s1_t0_q ^ s1_t1_q ^ s1_t2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_t0_q    <= '0;
            s1_t1_q    <= '0;
            s1_t2_q    <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_tag_q   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_t0_q  <= t0_d;
                    s1_t1_q  <= t1_d;
                    s1_t2_q  <= t2_d;
                    s1_tag_q <= in_tag;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s2_data_d;
                    s2_tag_q  <= s1_tag_q;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_sha_shift_pipe.sv
module tb_sha_shift_pipe;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic [2:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;

    int checks = 0;
    int passes = 0;
    logic [TW+W-1:0] sb[$];

    sha_shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Reference model: bit-by-bit index arithmetic.
    function automatic logic [W-1:0] m_rotr(input logic [W-1:0] x, input int n);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = x[(i + n) % W];
        return r;
    endfunction

    function automatic logic [W-1:0] m_shr(input logic [W-1:0] x, input int n);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = (i + n < W) ? x[(i + n) % W] : 1'b0;
        return r;
    endfunction

    function automatic logic [W-1:0] m_shl(input logic [W-1:0] x, input int n);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = (i >= n) ? x[(i - n + W) % W] : 1'b0;
        return r;
    endfunction

    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [AW-1:0] amt,
                                           input logic [W-1:0] x);
        int n;
        n = int'(amt);
        case (op)
            3'd0: return m_rotr(x, n);
            3'd1: return m_rotr(x, (W - n) % W);
            3'd2: return m_shr(x, n);
            3'd3: return m_shl(x, n);
            3'd4: return m_rotr(x, 2) ^ m_rotr(x, 13) ^ m_rotr(x, 22);
            3'd5: return m_rotr(x, 6) ^ m_rotr(x, 11) ^ m_rotr(x, 25);
            3'd6: return m_rotr(x, 7) ^ m_rotr(x, 18) ^ m_shr(x, 3);
            default: return m_rotr(x, 17) ^ m_rotr(x, 19) ^ m_shr(x, 10);
        endcase
    endfunction

    // Drives one cycle at the falling edge and reports which transfers the
    // next rising edge will perform, plus the output values seen.
    task automatic drive(input logic iv, input logic [W-1:0] d, input logic [AW-1:0] a,
                         input logic [2:0] op, input logic [TW-1:0] tg, input logic ordy,
                         output logic acc, output logic emit,
                         output logic [W-1:0] od, output logic [TW-1:0] ot);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_amt    = a;
        in_op     = op;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        acc  = iv && in_ready;
        emit = out_valid && ordy;
        od   = out_data;
        ot   = out_tag;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
        checks++; if (out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", out_data); else passes++;
        checks++; if (out_tag !== '0) $display("FAIL reset_out_tag got=%h exp=0", out_tag); else passes++;
    endtask

    task automatic test_single(input string name, input logic [2:0] op, input logic [AW-1:0] amt,
                               input logic [W-1:0] d, input logic [W-1:0] exp, input logic [TW-1:0] tg);
        logic acc, emit;
        logic [W-1:0] od;
        logic [TW-1:0] ot;
        int lat;
        logic [W-1:0] got;
        logic [TW-1:0] gtag;
        lat = -1; got = '0; gtag = '0;
        drive(1'b1, d, amt, op, tg, 1'b1, acc, emit, od, ot);
        checks++; if (acc !== 1'b1) $display("FAIL %s_accept got=%b exp=1", name, acc); else passes++;
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, '0, '0, '0, '0, 1'b1, acc, emit, od, ot);
            if (emit && lat < 0) begin lat = k; got = od; gtag = ot; end
        end
        checks++; if (lat != 2) $display("FAIL %s_latency got=%0d exp=2", name, lat); else passes++;
        checks++; if (got !== exp) $display("FAIL %s_data got=%h exp=%h", name, got, exp); else passes++;
        checks++; if (gtag !== tg) $display("FAIL %s_tag got=%h exp=%h", name, gtag, tg); else passes++;
    endtask

    task automatic test_back_to_back();
        logic acc, emit;
        logic [W-1:0] od, d;
        logic [TW-1:0] ot;
        logic [2:0] op;
        logic [AW-1:0] a;
        logic [TW+W-1:0] e;
        int nemit;
        nemit = 0;
        for (int c = 0; c < 18; c++) begin
            d = $urandom; op = 3'($urandom_range(0, 7)); a = AW'($urandom_range(0, W-1));
            drive(c < 16, d, a, op, TW'(c), 1'b1, acc, emit, od, ot);
            if (c < 16) begin
                checks++; if (acc !== 1'b1) $display("FAIL b2b_accept cycle=%0d got=%b exp=1", c, acc); else passes++;
            end
            if (acc) sb.push_back({TW'(c), model(op, a, d)});
            if (c >= 2) begin
                checks++; if (emit !== 1'b1) $display("FAIL b2b_out_valid cycle=%0d got=%b exp=1", c, emit); else passes++;
            end
            if (emit) begin
                nemit++;
                checks++;
                if (sb.size() == 0) $display("FAIL b2b_spurious got tag=%h exp=none", ot);
                else begin
                    e = sb.pop_front();
                    if ({ot, od} !== e) $display("FAIL b2b_result got=%h exp=%h", {ot, od}, e); else passes++;
                end
            end
        end
        checks++; if (nemit != 16) $display("FAIL b2b_count got=%0d exp=16", nemit); else passes++;
    endtask

    task automatic test_stall();
        logic acc, emit, ordy;
        logic [W-1:0] od, held;
        logic [TW-1:0] ot;
        logic [TW+W-1:0] e;
        logic [W-1:0] wd [8];
        logic [2:0] wop [8];
        logic [AW-1:0] wa [8];
        int idx, nemit;
        idx = 0; nemit = 0; held = '0;
        for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom; wop[i] = 3'($urandom_range(0, 7)); wa[i] = AW'($urandom_range(0, W-1));
        end
        for (int c = 0; c < 40; c++) begin
            ordy = !(c >= 3 && c < 8);
            if (idx < 8) drive(1'b1, wd[idx], wa[idx], wop[idx], TW'(idx), ordy, acc, emit, od, ot);
            else         drive(1'b0, '0, '0, '0, '0, ordy, acc, emit, od, ot);
            if (c >= 3 && c < 8) begin
                checks++; if (acc !== 1'b0) $display("FAIL stall_in_ready cycle=%0d got=%b exp=0", c, acc); else passes++;
            end
            if (c == 3) held = od;
            if (c > 3 && c < 8) begin
                checks++; if (od !== held) $display("FAIL stall_hold cycle=%0d got=%h exp=%h", c, od, held); else passes++;
            end
            if (c == 7) begin
                checks++; if (sb.size() > 2) $display("FAIL stall_inflight got=%0d exp<=2", sb.size()); else passes++;
            end
            if (acc) begin
                sb.push_back({TW'(idx), model(wop[idx], wa[idx], wd[idx])});
                idx++;
            end
            if (emit) begin
                nemit++;
                checks++;
                if (sb.size() == 0) $display("FAIL stall_spurious got tag=%h exp=none", ot);
                else begin
                    e = sb.pop_front();
                    if ({ot, od} !== e) $display("FAIL stall_result got=%h exp=%h", {ot, od}, e); else passes++;
                end
            end
            if (idx == 8 && sb.size() == 0 && c >= 8) break;
        end
        checks++; if (nemit != 8) $display("FAIL stall_count got=%0d exp=8", nemit); else passes++;
    endtask

    task automatic test_async_reset();
        logic acc, emit;
        logic [W-1:0] od;
        logic [TW-1:0] ot;
        int stale;
        drive(1'b1, 32'h11111111, 5'd1, 3'd0, 4'h1, 1'b1, acc, emit, od, ot);
        drive(1'b1, 32'h22222222, 5'd2, 3'd0, 4'h2, 1'b1, acc, emit, od, ot);
        #5;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL arst_pre_valid got=%b exp=1", out_valid); else passes++;
        #1 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid got=%b exp=0", out_valid); else passes++;
        checks++; if (out_data !== '0) $display("FAIL arst_out_data got=%h exp=0", out_data); else passes++;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        stale = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, '0, '0, '0, 1'b1, acc, emit, od, ot);
            if (emit) stale++;
        end
        checks++; if (stale != 0) $display("FAIL arst_stale got=%0d exp=0", stale); else passes++;
        test_single("arst_next", 3'd0, 5'd4, 32'h12345678, 32'h81234567, 4'h9);
    endtask

    task automatic test_random();
        logic acc, emit, have, ordy;
        logic [W-1:0] od, d;
        logic [TW-1:0] ot, tg;
        logic [2:0] op;
        logic [AW-1:0] a;
        logic [TW+W-1:0] e;
        int n, cyc, cov0, covmax;
        n = 0; cyc = 0; cov0 = 0; covmax = 0; have = 1'b0;
        d = '0; op = '0; a = '0; tg = '0;
        while (n < 10000 && cyc < 60000) begin
            if (!have && $urandom_range(0, 4) != 0) begin
                have = 1'b1;
                d = $urandom; op = 3'($urandom_range(0, 7)); tg = TW'($urandom);
                if (n % 64 == 0)      a = '0;
                else if (n % 64 == 1) a = AW'(W - 1);
                else                  a = AW'($urandom_range(0, W-1));
            end
            ordy = ($urandom_range(0, 3) != 0);
            drive(have, d, a, op, tg, ordy, acc, emit, od, ot);
            cyc++;
            if (acc) begin
                sb.push_back({tg, model(op, a, d)});
                if (op < 3'd4 && a == '0) cov0++;
                if (op < 3'd4 && a == AW'(W - 1)) covmax++;
                have = 1'b0;
                n++;
            end
            if (emit) begin
                checks++;
                if (sb.size() == 0) $display("FAIL rand_spurious got tag=%h exp=none", ot);
                else begin
                    e = sb.pop_front();
                    if ({ot, od} !== e) $display("FAIL rand_result n=%0d got=%h exp=%h", n, {ot, od}, e); else passes++;
                end
            end
        end
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            drive(1'b0, '0, '0, '0, '0, 1'b1, acc, emit, od, ot);
            if (emit) begin
                checks++;
                e = sb.pop_front();
                if ({ot, od} !== e) $display("FAIL rand_drain got=%h exp=%h", {ot, od}, e); else passes++;
            end
        end
        checks++; if (n != 10000) $display("FAIL rand_accepted got=%0d exp=10000", n); else passes++;
        checks++; if (sb.size() != 0) $display("FAIL rand_leftover got=%0d exp=0", sb.size()); else passes++;
        checks++; if (cov0 == 0) $display("FAIL rand_cov_amt0 got=%0d exp>0", cov0); else passes++;
        checks++; if (covmax == 0) $display("FAIL rand_cov_amtmax got=%0d exp>0", covmax); else passes++;
    endtask

    initial begin
        test_reset();
        test_single("rotr4",  3'd0, 5'd4,  32'h12345678, 32'h81234567, 4'h1);
        test_single("rotl8",  3'd1, 5'd8,  32'h12345678, 32'h34567812, 4'h2);
        test_single("shr4",   3'd2, 5'd4,  32'h80000000, 32'h08000000, 4'h3);
        test_single("shl31",  3'd3, 5'd31, 32'h00000003, 32'h80000000, 4'h4);
        test_single("rotr0",  3'd0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 4'h5);
        test_single("bsig0",  3'd4, 5'd7,  32'h00000001, 32'h40080400, 4'h6);
        test_single("bsig1",  3'd5, 5'd0,  32'h00000001, 32'h04200080, 4'h7);
        test_single("ssig0",  3'd6, 5'd3,  32'h00000001, 32'h02004000, 4'h8);
        test_single("ssig1",  3'd7, 5'd31, 32'h00000001, 32'h0000A000, 4'hB);
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
